// File: rtl/mmio_csr_responder.sv
// CCI-P MMIO responder: decodes host MMIO reads/writes against the DFH CSR map and user registers,
// returning read data on a fixed two-stage pipeline.
module mmio_csr_responder #(
   parameter int unsigned NUM_USER_REGS = 8,
   parameter logic [63:0] DFH_VALUE     = 64'h1000_0000_0000_1001,
   parameter logic [63:0] AFU_ID_L      = 64'h0,
   parameter logic [63:0] AFU_ID_H      = 64'h0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mmio_rd_valid,
   input  logic                         mmio_wr_valid,
   input  logic [15:0]                  mmio_addr,
   input  logic [1:0]                   mmio_len,
   input  logic [8:0]                   mmio_tid,
   input  logic [63:0]                  mmio_wdata,
   input  logic [63:0]                  status_in,
   output logic                         rsp_valid,
   output logic [8:0]                   rsp_tid,
   output logic [63:0]                  rsp_data,
   output logic [64*NUM_USER_REGS-1:0]  user_regs,
   output logic                         start_pulse
);

   localparam logic [14:0] QwDfh      = 15'd0;
   localparam logic [14:0] QwAfuIdL   = 15'd1;
   localparam logic [14:0] QwAfuIdH   = 15'd2;
   localparam logic [14:0] QwScratch  = 15'd8;
   localparam logic [14:0] QwCtrl     = 15'd9;
   localparam logic [14:0] QwStatus   = 15'd10;
   localparam logic [14:0] QwCounters = 15'd11;
   localparam logic [14:0] QwUser     = 15'd16;

   logic [14:0] qidx;
   logic [63:0] scratch_q;
   logic [63:0] user_q [NUM_USER_REGS];
   logic [31:0] rd_count_q;
   logic [31:0] wr_count_q;
   logic        s1_valid_q;
   logic [8:0]  s1_tid_q;
   logic [63:0] s1_data_q;

   logic [63:0] reg_rd;
   logic [63:0] rd_sel;
   logic [63:0] wr_mask;
   logic [63:0] wr_val;
   logic        wr_ok;
   logic        start_d;
   logic        cnt_clr;

   assign qidx = mmio_addr[15:1];

   always_comb begin
      reg_rd = '0;
      unique case (qidx)
         QwDfh:      reg_rd = DFH_VALUE;
         QwAfuIdL:   reg_rd = AFU_ID_L;
         QwAfuIdH:   reg_rd = AFU_ID_H;
         QwScratch:  reg_rd = scratch_q;
         QwStatus:   reg_rd = status_in;
         QwCounters: reg_rd = {rd_count_q, wr_count_q};
         default: begin
            for (int unsigned i = 0; i < NUM_USER_REGS; i++) begin
               if (qidx == QwUser + 15'(i)) reg_rd = user_q[i];
            end
         end
      endcase
      case (mmio_len)
         2'd0:    rd_sel = {32'h0, mmio_addr[0] ? reg_rd[63:32] : reg_rd[31:0]};
         2'd1:    rd_sel = reg_rd;
         default: rd_sel = '0;
      endcase
   end

   // 4 B writes carry their data in the low DWORD; replicate it and let the mask pick the half.
   assign wr_ok   = mmio_wr_valid && !mmio_len[1];
   assign wr_mask = mmio_len[0] ? '1 :
                    (mmio_addr[0] ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF});
   assign wr_val  = mmio_len[0] ? mmio_wdata : {2{mmio_wdata[31:0]}};
   assign start_d = wr_ok && (qidx == QwCtrl) && wr_mask[0] && wr_val[0];
   assign cnt_clr = wr_ok && (qidx == QwCounters);

   always_comb begin
      user_regs = '0;
      for (int unsigned i = 0; i < NUM_USER_REGS; i++) begin
         user_regs[64*i +: 64] = user_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scratch_q   <= '0;
         for (int unsigned i = 0; i < NUM_USER_REGS; i++) user_q[i] <= '0;
         rd_count_q  <= '0;
         wr_count_q  <= '0;
         start_pulse <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_tid_q    <= '0;
         s1_data_q   <= '0;
         rsp_valid   <= 1'b0;
         rsp_tid     <= '0;
         rsp_data    <= '0;
      end else begin
         if (wr_ok && (qidx == QwScratch)) begin
            scratch_q <= (scratch_q & ~wr_mask) | (wr_val & wr_mask);
         end
         for (int unsigned i = 0; i < NUM_USER_REGS; i++) begin
            if (wr_ok && (qidx == QwUser + 15'(i))) begin
               user_q[i] <= (user_q[i] & ~wr_mask) | (wr_val & wr_mask);
            end
         end
         // A counter clear overrides both increments from the same cycle.
         if (cnt_clr) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
         end else begin
            if (mmio_rd_valid) rd_count_q <= rd_count_q + 32'd1;
            if (mmio_wr_valid) wr_count_q <= wr_count_q + 32'd1;
         end
         start_pulse <= start_d;
         s1_valid_q  <= mmio_rd_valid;
         s1_tid_q    <= mmio_tid;
         s1_data_q   <= rd_sel;
         rsp_valid   <= s1_valid_q;
         rsp_tid     <= s1_tid_q;
         rsp_data    <= s1_data_q;
      end
   end

endmodule

// File: tb/tb_mmio_csr_responder.sv
// Directed bench for mmio_csr_responder: a register-map model predicts every response, user
// register value and start pulse; literal expectations pin the model on the key scenarios.
module tb_mmio_csr_responder;

   localparam int unsigned NU      = 8;
   localparam logic [63:0] DFH     = 64'h1000_0000_0000_1001;
   localparam logic [63:0] AFU_L   = 64'h1111_2222_3333_4444;
   localparam logic [63:0] AFU_H   = 64'h5555_6666_7777_8888;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            mmio_rd_valid = 1'b0;
   logic            mmio_wr_valid = 1'b0;
   logic [15:0]     mmio_addr = '0;
   logic [1:0]      mmio_len = '0;
   logic [8:0]      mmio_tid = '0;
   logic [63:0]     mmio_wdata = '0;
   logic [63:0]     status_in = '0;
   logic            rsp_valid;
   logic [8:0]      rsp_tid;
   logic [63:0]     rsp_data;
   logic [64*NU-1:0] user_regs;
   logic            start_pulse;

   mmio_csr_responder #(
      .NUM_USER_REGS(NU),
      .DFH_VALUE    (DFH),
      .AFU_ID_L     (AFU_L),
      .AFU_ID_H     (AFU_H)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mmio_rd_valid(mmio_rd_valid),
      .mmio_wr_valid(mmio_wr_valid),
      .mmio_addr    (mmio_addr),
      .mmio_len     (mmio_len),
      .mmio_tid     (mmio_tid),
      .mmio_wdata   (mmio_wdata),
      .status_in    (status_in),
      .rsp_valid    (rsp_valid),
      .rsp_tid      (rsp_tid),
      .rsp_data     (rsp_data),
      .user_regs    (user_regs),
      .start_pulse  (start_pulse)
   );

   always #5 clk = ~clk;

   typedef struct { int due; logic [8:0] tid; logic [63:0] data; } exp_t;
   typedef struct { logic [8:0] tid; logic [63:0] data; } obs_t;

   exp_t        exp_q[$];
   obs_t        obs_q[$];
   int          total = 0;
   int          bad = 0;
   int          ecnt = 0;
   int          n_start = 0;
   bit          chk_en = 1'b0;
   logic [63:0] m_scratch;
   logic [63:0] m_user [NU];
   logic [31:0] m_rd, m_wr;
   logic        m_start;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] m_read(input logic [15:0] a, input logic [1:0] len);
      logic [63:0] q;
      int          base;
      base = int'(a) & 32'hFFFE;
      q = 64'h0;
      if (base == 'h0000) q = DFH;
      if (base == 'h0002) q = AFU_L;
      if (base == 'h0004) q = AFU_H;
      if (base == 'h0010) q = m_scratch;
      if (base == 'h0014) q = status_in;
      if (base == 'h0016) q = {m_rd, m_wr};
      if (base >= 'h0020 && base < 'h0020 + 2 * int'(NU)) q = m_user[(base - 'h20) / 2];
      if (len == 2'd1) return q;
      if (len == 2'd0) return a[0] ? (q >> 32) : (q & 64'h0000_0000_FFFF_FFFF);
      return 64'h0;
   endfunction

   // Model state: reset clears everything asynchronously, like the device.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_scratch = '0;
         for (int i = 0; i < int'(NU); i++) m_user[i] = '0;
         m_rd = '0;
         m_wr = '0;
         m_start = 1'b0;
         exp_q.delete();
      end else begin
         logic [63:0] mask, val;
         int          base;
         bit          clr;
         ecnt++;
         m_start = 1'b0;
         clr = 1'b0;
         if (mmio_rd_valid)
            exp_q.push_back('{due: ecnt + 1, tid: mmio_tid, data: m_read(mmio_addr, mmio_len)});
         if (mmio_wr_valid && mmio_len < 2) begin
            base = int'(mmio_addr) & 32'hFFFE;
            if (mmio_len == 2'd1) begin
               mask = '1;
               val = mmio_wdata;
            end else if (mmio_addr[0]) begin
               mask = 64'hFFFF_FFFF_0000_0000;
               val = {mmio_wdata[31:0], 32'h0};
            end else begin
               mask = 64'h0000_0000_FFFF_FFFF;
               val = {32'h0, mmio_wdata[31:0]};
            end
            if (base == 'h0010) m_scratch = (m_scratch & ~mask) | val;
            if (base == 'h0012 && val[0]) m_start = 1'b1;
            if (base == 'h0016) clr = 1'b1;
            if (base >= 'h0020 && base < 'h0020 + 2 * int'(NU))
               m_user[(base - 'h20) / 2] = (m_user[(base - 'h20) / 2] & ~mask) | val;
         end
         if (clr) begin
            m_rd = '0;
            m_wr = '0;
         end else begin
            if (mmio_rd_valid) m_rd = m_rd + 1;
            if (mmio_wr_valid) m_wr = m_wr + 1;
         end
      end
   end

   // Compare process: every negedge once enabled.
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) obs_q.push_back('{tid: rsp_tid, data: rsp_data});
      if (start_pulse === 1'b1) n_start++;
      if (chk_en) begin
         bit ev;
         ev = (exp_q.size() > 0) && (exp_q[0].due == ecnt);
         chk("rsp_valid", {63'h0, rsp_valid}, {63'h0, ev});
         if (ev) begin
            chk("rsp_tid", {55'h0, rsp_tid}, {55'h0, exp_q[0].tid});
            chk("rsp_data", rsp_data, exp_q[0].data);
            void'(exp_q.pop_front());
         end
         for (int i = 0; i < int'(NU); i++) chk("user_regs", user_regs[64*i +: 64], m_user[i]);
         chk("start_pulse", {63'h0, start_pulse}, {63'h0, m_start});
      end
   end

   task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] len,
                      input logic [8:0] tid, input logic [63:0] wd);
      @(posedge clk);
      #1;
      mmio_rd_valid = rd;
      mmio_wr_valid = wr;
      mmio_addr = a;
      mmio_len = len;
      mmio_tid = tid;
      mmio_wdata = wd;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) req(1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      mmio_rd_valid = 1'b0;
      mmio_wr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic lit(input string name, input int idx, input logic [8:0] tid,
                      input logic [63:0] data);
      if (idx >= obs_q.size()) begin
         chk({name, "_present"}, 64'(obs_q.size()), 64'(idx + 1));
      end else begin
         chk({name, "_tid"}, {55'h0, obs_q[idx].tid}, {55'h0, tid});
         chk({name, "_data"}, obs_q[idx].data, data);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
      chk("reset_rsp_data", rsp_data, 64'h0);
      chk("reset_user_regs", user_regs[63:0], 64'h0);
      chk_en = 1'b1;

      // ID reads back to back
      idle(5);
      obs_q.delete();
      req(1, 0, 16'h0000, 2'd1, 9'd1, 64'h0);
      req(1, 0, 16'h0002, 2'd1, 9'd2, 64'h0);
      req(1, 0, 16'h0004, 2'd1, 9'd3, 64'h0);
      idle(4);
      lit("dfh", 0, 9'd1, 64'h1000_0000_0000_1001);
      lit("afu_l", 1, 9'd2, 64'h1111_2222_3333_4444);
      lit("afu_h", 2, 9'd3, 64'h5555_6666_7777_8888);

      // scratch write then upper DWORD read
      obs_q.delete();
      req(0, 1, 16'h0010, 2'd1, 9'd0, 64'hDEAD_BEEF_0123_4567);
      req(1, 0, 16'h0011, 2'd0, 9'd4, 64'h0);
      idle(4);
      lit("scratch_hi", 0, 9'd4, 64'h0000_0000_DEAD_BEEF);

      // 4 B user register write, 8 B read
      obs_q.delete();
      req(0, 1, 16'h0023, 2'd0, 9'd0, 64'h0000_0000_AAAA_5555);
      req(1, 0, 16'h0022, 2'd1, 9'd5, 64'h0);
      idle(4);
      lit("user1", 0, 9'd5, 64'hAAAA_5555_0000_0000);
      chk("user_regs_1", user_regs[127:64], 64'hAAAA_5555_0000_0000);

      // CTRL pulse, CTRL read, unmapped read
      obs_q.delete();
      n_start = 0;
      req(0, 1, 16'h0012, 2'd1, 9'd0, 64'h1);
      req(1, 0, 16'h0012, 2'd1, 9'd6, 64'h0);
      req(1, 0, 16'h0100, 2'd1, 9'h1FF, 64'h0);
      idle(4);
      chk("start_count", 64'(n_start), 64'd1);
      lit("ctrl_rd", 0, 9'd6, 64'h0);
      lit("unmapped", 1, 9'h1FF, 64'h0);

      // status, simultaneous rd/wr, unsupported lengths
      obs_q.delete();
      status_in = 64'hCAFE_F00D_1234_5678;
      req(1, 0, 16'h0015, 2'd0, 9'h10, 64'h0);
      req(1, 1, 16'h0010, 2'd1, 9'h11, 64'h1122_3344_5566_7788);
      req(1, 0, 16'h0010, 2'd1, 9'h12, 64'h0);
      req(0, 1, 16'h0010, 2'd2, 9'h0, 64'h0);
      req(1, 0, 16'h0010, 2'd1, 9'h13, 64'h0);
      req(1, 0, 16'h0010, 2'd3, 9'h14, 64'h0);
      idle(4);
      lit("status_hi", 0, 9'h10, 64'h0000_0000_CAFE_F00D);
      lit("rdwr_pre", 1, 9'h11, 64'hDEAD_BEEF_0123_4567);
      lit("rdwr_post", 2, 9'h12, 64'h1122_3344_5566_7788);
      lit("len2_wr_ignored", 3, 9'h13, 64'h1122_3344_5566_7788);
      lit("len3_rd_zero", 4, 9'h14, 64'h0);

      // counters
      do_reset();
      idle(2);
      obs_q.delete();
      req(1, 0, 16'h0010, 2'd1, 9'd1, 64'h0);
      req(1, 0, 16'h0010, 2'd1, 9'd2, 64'h0);
      req(1, 0, 16'h0010, 2'd1, 9'd3, 64'h0);
      req(0, 1, 16'h0010, 2'd1, 9'd0, 64'h5);
      req(0, 1, 16'h0010, 2'd1, 9'd0, 64'h6);
      req(1, 0, 16'h0016, 2'd1, 9'd7, 64'h0);
      req(0, 1, 16'h0016, 2'd1, 9'd0, 64'h0);
      req(1, 0, 16'h0016, 2'd1, 9'd8, 64'h0);
      idle(4);
      lit("counters", 3, 9'd7, 64'h0000_0003_0000_0002);
      lit("counters_clr", 4, 9'd8, 64'h0);

      // reads every cycle, reset mid-stream
      obs_q.delete();
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (i == 10) rst = 1'b1;
         mmio_rd_valid = 1'b1;
         mmio_wr_valid = 1'b0;
         mmio_addr = 16'h0000;
         mmio_len = 2'd1;
         mmio_tid = 9'(i + 1);
      end
      @(posedge clk);
      #1;
      mmio_rd_valid = 1'b0;
      rst = 1'b0;
      idle(6);
      chk("burst_count", 64'(obs_q.size()), 64'd8);
      lit("burst_last", 7, 9'd8, 64'h1000_0000_0000_1001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
